// File: rtl/axi4_lite_slave_if_if.sv
// rtl/axi4_lite_slave_if_if.sv - AXI4-Lite bus bundle between a master and axi4_lite_slave_if
interface axi4_lite_slave_if_if;
  logic [31:0] S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axi4_lite_slave_if.sv
// rtl/axi4_lite_slave_if.sv - AXI4-Lite slave front end with window decode, round-robin and timeout
module axi4_lite_slave_if #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] SIZE_BYTES     = 32'h0000_1000,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi4_lite_slave_if_if.slave   s_axi,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  input  logic                  mem_error
);
  typedef enum logic [2:0] {IDLE, WR_ACCESS, WR_RESP, RD_ACCESS, RD_RESP} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              prefer_wr;
  logic              aw_full, w_full, ar_full;
  logic              awready_q, wready_q, arready_q;
  logic [31:0]       aw_addr, ar_addr, w_data;
  logic [3:0]        w_strb;
  logic              bvalid_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q;

  logic        aw_hs, w_hs, ar_hs;
  logic        pick_wr, pick_rd;
  logic [31:0] req_addr, off;
  logic        in_win;
  logic        aw_full_nxt, w_full_nxt, ar_full_nxt;
  logic [1:0]  acc_resp;
  logic        unused_prot;

  assign aw_hs = s_axi.S_AXI_AWVALID && awready_q;
  assign w_hs  = s_axi.S_AXI_WVALID  && wready_q;
  assign ar_hs = s_axi.S_AXI_ARVALID && arready_q;

  // prefer_wr is cleared after a write and set after a read, so the other type wins a tie
  assign pick_wr = (state == IDLE) && aw_full && w_full && (!ar_full || prefer_wr);
  assign pick_rd = (state == IDLE) && ar_full && !pick_wr;

  assign req_addr = pick_wr ? aw_addr : ar_addr;
  assign off      = req_addr - BASE_ADDR;
  assign in_win   = (req_addr >= BASE_ADDR) && (off < SIZE_BYTES);

  assign aw_full_nxt = (aw_full && !pick_wr) || aw_hs;
  assign w_full_nxt  = (w_full  && !pick_wr) || w_hs;
  assign ar_full_nxt = (ar_full && !pick_rd) || ar_hs;

  assign acc_resp    = mem_error ? 2'b10 : 2'b00;
  assign unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      prefer_wr <= 1'b0;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      ar_full   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      aw_addr   <= '0;
      ar_addr   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      aw_full   <= aw_full_nxt;
      w_full    <= w_full_nxt;
      ar_full   <= ar_full_nxt;
      awready_q <= !aw_full_nxt;
      wready_q  <= !w_full_nxt;
      arready_q <= !ar_full_nxt;
      if (aw_hs) aw_addr <= s_axi.S_AXI_AWADDR;
      if (ar_hs) ar_addr <= s_axi.S_AXI_ARADDR;
      if (w_hs) begin
        w_data <= s_axi.S_AXI_WDATA;
        w_strb <= s_axi.S_AXI_WSTRB;
      end

      case (state)
        IDLE: begin
          if (pick_wr || pick_rd) begin
            cnt <= '0;
            if (!in_win) begin
              if (pick_wr) begin
                state    <= WR_RESP;
                bvalid_q <= 1'b1;
                bresp_q  <= 2'b11;
              end else begin
                state    <= RD_RESP;
                rvalid_q <= 1'b1;
                rresp_q  <= 2'b11;
                rdata_q  <= '0;
              end
            end else begin
              state     <= pick_wr ? WR_ACCESS : RD_ACCESS;
              mem_req   <= 1'b1;
              mem_wr    <= pick_wr;
              mem_addr  <= {off[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata <= pick_wr ? w_data : 32'h0;
              mem_wstrb <= pick_wr ? w_strb : 4'h0;
            end
          end
        end
        WR_ACCESS, RD_ACCESS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (state == WR_ACCESS) begin
              state    <= WR_RESP;
              bvalid_q <= 1'b1;
              bresp_q  <= acc_resp;
            end else begin
              state    <= RD_RESP;
              rvalid_q <= 1'b1;
              rresp_q  <= acc_resp;
              rdata_q  <= mem_rdata;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_MAX)) begin
            // give up on the peripheral; a late mem_ready lands in IDLE and is ignored
            mem_req <= 1'b0;
            if (state == WR_ACCESS) begin
              state    <= WR_RESP;
              bvalid_q <= 1'b1;
              bresp_q  <= 2'b10;
            end else begin
              state    <= RD_RESP;
              rvalid_q <= 1'b1;
              rresp_q  <= 2'b10;
              rdata_q  <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            state     <= IDLE;
            prefer_wr <= 1'b0;
          end
        end
        RD_RESP: begin
          if (s_axi.S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            state     <= IDLE;
            prefer_wr <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_slave_if.sv
// tb/tb_axi4_lite_slave_if.sv - scoreboard testbench for axi4_lite_slave_if
module tb_axi4_lite_slave_if;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SIZE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_lite_slave_if_if bus();
  logic        mem_req, mem_wr, mem_ready, mem_error;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  axi4_lite_slave_if #(
    .BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .ADDR_WIDTH(12), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_axi(bus.slave),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_error(mem_error)
  );

  typedef struct packed {logic wr; logic [11:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} mem_t;
  typedef struct packed {logic [1:0] resp; logic [31:0] data;} rsp_t;

  mem_t exp_mem[$];
  rsp_t exp_b[$];
  rsp_t exp_r[$];
  int n_tests = 0, n_fail = 0, cyc = 0, hs_cyc = 0, b_first_cyc = 0;
  int req_len = 0, last_len = 0, req_rises = 0, rises0 = 0;
  logic [31:0] mem_arr [0:1023];
  logic hang = 1'b0, err_next = 1'b0, late_pulse = 1'b0;
  logic m_seen = 1'b0, b_seen = 1'b0, r_seen = 1'b0;
  mem_t me;
  rsp_t b_hold, r_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic exp_m(input logic wr, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_t e;
    e.wr = wr; e.addr = a; e.wdata = d; e.wstrb = s;
    exp_mem.push_back(e);
  endtask

  task automatic exp_rsp(input logic is_rd, input logic [1:0] resp, input logic [31:0] d);
    rsp_t e;
    e.resp = resp; e.data = d;
    if (is_rd) exp_r.push_back(e); else exp_b.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // peripheral model plus monitors for the mem, B and R sides
  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_error = 1'b0;
    mem_rdata = 32'h0;
    if (!rst_n) begin
      m_seen = 1'b0; b_seen = 1'b0; r_seen = 1'b0; req_len = 0;
    end else begin
      if (mem_req) begin
        req_len++;
        if (!m_seen) begin
          m_seen = 1'b1;
          req_rises++;
          if (exp_mem.size() == 0) bad("unexpected_mem_req");
          else begin
            me = exp_mem.pop_front();
            chk("mem_wr", {31'h0, mem_wr}, {31'h0, me.wr});
            chk("mem_addr", {20'h0, mem_addr}, {20'h0, me.addr});
            chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, me.wstrb});
            if (me.wr) chk("mem_wdata", mem_wdata, me.wdata);
          end
        end
        if (!hang) begin
          mem_ready = 1'b1;
          mem_error = err_next;
          if (mem_wr) begin
            for (int i = 0; i < 4; i++)
              if (mem_wstrb[i]) mem_arr[mem_addr[11:2]][8*i +: 8] = mem_wdata[8*i +: 8];
          end else mem_rdata = mem_arr[mem_addr[11:2]];
        end
      end else begin
        if (req_len > 0) last_len = req_len;
        req_len = 0;
        m_seen = 1'b0;
        if (late_pulse) begin
          mem_ready = 1'b1;
          mem_rdata = 32'hBAD0BAD0;
          late_pulse = 1'b0;
        end
      end

      if (bus.S_AXI_BVALID) begin
        if (!b_seen) begin
          b_seen = 1'b1;
          b_first_cyc = cyc;
          if (exp_b.size() == 0) bad("unexpected_bvalid");
          else begin
            b_hold = exp_b.pop_front();
            chk("bresp", {30'h0, bus.S_AXI_BRESP}, {30'h0, b_hold.resp});
          end
        end else chk("bresp_stable", {30'h0, bus.S_AXI_BRESP}, {30'h0, b_hold.resp});
        if (bus.S_AXI_BREADY) b_seen = 1'b0;
      end

      if (bus.S_AXI_RVALID) begin
        if (!r_seen) begin
          r_seen = 1'b1;
          if (exp_r.size() == 0) bad("unexpected_rvalid");
          else begin
            r_hold = exp_r.pop_front();
            chk("rresp", {30'h0, bus.S_AXI_RRESP}, {30'h0, r_hold.resp});
            chk("rdata", bus.S_AXI_RDATA, r_hold.data);
          end
        end else chk("rdata_stable", bus.S_AXI_RDATA, r_hold.data);
        if (bus.S_AXI_RREADY) r_seen = 1'b0;
      end
    end
  end

  function automatic logic rdy(input int ch);
    case (ch)
      0:       return bus.S_AXI_AWREADY;
      1:       return bus.S_AXI_WREADY;
      default: return bus.S_AXI_ARREADY;
    endcase
  endfunction

  task automatic set_valid(input int ch, input logic v);
    case (ch)
      0:       bus.S_AXI_AWVALID = v;
      1:       bus.S_AXI_WVALID = v;
      default: bus.S_AXI_ARVALID = v;
    endcase
  endtask

  // ch: 0 = AW, 1 = W, 2 = AR
  task automatic do_hs(input int ch, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(posedge clk); #1;
    case (ch)
      0:       bus.S_AXI_AWADDR = a;
      1:       begin bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s; end
      default: bus.S_AXI_ARADDR = a;
    endcase
    set_valid(ch, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy(ch) && n < 200);
    if (!rdy(ch)) bad("handshake_timeout");
    @(posedge clk); #1;
    if (ch == 0) hs_cyc = cyc;
    set_valid(ch, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0 || exp_mem.size() != 0 ||
            bus.S_AXI_BVALID || bus.S_AXI_RVALID) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      bad("drain_timeout");
      exp_b.delete(); exp_r.delete(); exp_mem.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem_arr[i] = 32'h0;
    bus.S_AXI_AWADDR = 0; bus.S_AXI_AWPROT = 0; bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WDATA = 0; bus.S_AXI_WSTRB = 0; bus.S_AXI_WVALID = 0;
    bus.S_AXI_ARADDR = 0; bus.S_AXI_ARPROT = 0; bus.S_AXI_ARVALID = 0;
    bus.S_AXI_BREADY = 1; bus.S_AXI_RREADY = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", {31'h0, bus.S_AXI_AWREADY}, 0);
    chk("rst_wready", {31'h0, bus.S_AXI_WREADY}, 0);
    chk("rst_arready", {31'h0, bus.S_AXI_ARREADY}, 0);
    chk("rst_bvalid", {31'h0, bus.S_AXI_BVALID}, 0);
    chk("rst_rvalid", {31'h0, bus.S_AXI_RVALID}, 0);
    chk("rst_mem_req", {31'h0, mem_req}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("awready_after_rst", {31'h0, bus.S_AXI_AWREADY}, 1);
    chk("arready_after_rst", {31'h0, bus.S_AXI_ARREADY}, 1);

    // 1: AW and W together, immediate peripheral, two-cycle B latency
    exp_m(1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    exp_rsp(1'b0, 2'b00, 32'h0);
    fork
      do_hs(0, BASE + 32'h10, 32'h0, 4'h0);
      do_hs(1, 32'h0, 32'hDEADBEEF, 4'hF);
    join
    drain();
    chk("b_latency", b_first_cyc - hs_cyc, 2);

    // 2: W ahead of AW, partial strobe, then back-to-back reads incl. unaligned
    exp_m(1'b1, 12'h014, 32'hCAFEF00D, 4'b0011);
    exp_rsp(1'b0, 2'b00, 32'h0);
    do_hs(1, 32'h0, 32'hCAFEF00D, 4'b0011);
    @(negedge clk);
    chk("wready_drop", {31'h0, bus.S_AXI_WREADY}, 0);
    repeat (1) @(posedge clk);
    do_hs(0, BASE + 32'h14, 32'h0, 4'h0);
    drain();
    exp_m(1'b0, 12'h010, 32'h0, 4'h0);
    exp_rsp(1'b1, 2'b00, 32'hDEADBEEF);
    exp_m(1'b0, 12'h014, 32'h0, 4'h0);
    exp_rsp(1'b1, 2'b00, 32'h0000F00D);
    do_hs(2, BASE + 32'h10, 32'h0, 4'h0);
    do_hs(2, BASE + 32'h17, 32'h0, 4'h0);
    drain();

    // 3: first address past the window, then peripheral SLVERR on the last word
    rises0 = req_rises;
    exp_rsp(1'b1, 2'b11, 32'h0);
    do_hs(2, BASE + SIZE, 32'h0, 4'h0);
    exp_rsp(1'b0, 2'b11, 32'h0);
    fork
      do_hs(0, BASE + SIZE, 32'h0, 4'h0);
      do_hs(1, 32'h0, 32'h11111111, 4'hF);
    join
    drain();
    chk("decerr_no_req", req_rises, rises0);
    err_next = 1'b1;
    exp_m(1'b1, 12'hFFC, 32'h5A5A5A5A, 4'hF);
    exp_rsp(1'b0, 2'b10, 32'h0);
    fork
      do_hs(0, BASE + 32'hFFC, 32'h0, 4'h0);
      do_hs(1, 32'h0, 32'h5A5A5A5A, 4'hF);
    join
    drain();
    err_next = 1'b0;

    // 4: peripheral never answers, then a stray late mem_ready
    hang = 1'b1;
    exp_m(1'b0, 12'h020, 32'h0, 4'h0);
    exp_rsp(1'b1, 2'b10, 32'h0);
    do_hs(2, BASE + 32'h20, 32'h0, 4'h0);
    drain();
    chk("timeout_req_len", last_len, 9);
    late_pulse = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("late_ready_rvalid", {31'h0, bus.S_AXI_RVALID}, 0);
    chk("late_ready_mem_req", {31'h0, mem_req}, 0);
    hang = 1'b0;

    // 5: write pair and AR together after reset; read first, then order flips
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.S_AXI_BREADY = 0;
    exp_m(1'b0, 12'h010, 32'h0, 4'h0);
    exp_rsp(1'b1, 2'b00, 32'hDEADBEEF);
    exp_m(1'b1, 12'h018, 32'h0BADF00D, 4'hF);
    exp_rsp(1'b0, 2'b00, 32'h0);
    fork
      do_hs(0, BASE + 32'h18, 32'h0, 4'h0);
      do_hs(1, 32'h0, 32'h0BADF00D, 4'hF);
      do_hs(2, BASE + 32'h10, 32'h0, 4'h0);
    join
    n = 0;
    while (!bus.S_AXI_BVALID && n < 100) begin @(negedge clk); n++; end
    if (!bus.S_AXI_BVALID) bad("bvalid_wait");
    repeat (5) @(negedge clk);
    chk("bvalid_held", {31'h0, bus.S_AXI_BVALID}, 1);
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1;
    drain();
    exp_m(1'b0, 12'h014, 32'h0, 4'h0);
    exp_rsp(1'b1, 2'b00, 32'h0000F00D);
    do_hs(2, BASE + 32'h14, 32'h0, 4'h0);
    drain();
    exp_m(1'b1, 12'h01C, 32'h13572468, 4'hF);
    exp_rsp(1'b0, 2'b00, 32'h0);
    exp_m(1'b0, 12'h018, 32'h0, 4'h0);
    exp_rsp(1'b1, 2'b00, 32'h0BADF00D);
    fork
      do_hs(0, BASE + 32'h1C, 32'h0, 4'h0);
      do_hs(1, 32'h0, 32'h13572468, 4'hF);
      do_hs(2, BASE + 32'h18, 32'h0, 4'h0);
    join
    drain();

    // 6: asynchronous reset while a write sits in WR_ACCESS
    hang = 1'b1;
    exp_m(1'b1, 12'h030, 32'h77777777, 4'hF);
    fork
      do_hs(0, BASE + 32'h30, 32'h0, 4'h0);
      do_hs(1, 32'h0, 32'h77777777, 4'hF);
    join
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); n++; end
    if (!mem_req) bad("mem_req_wait");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mem_req", {31'h0, mem_req}, 0);
    chk("async_bvalid", {31'h0, bus.S_AXI_BVALID}, 0);
    chk("async_awready", {31'h0, bus.S_AXI_AWREADY}, 0);
    chk("async_wready", {31'h0, bus.S_AXI_WREADY}, 0);
    chk("async_arready", {31'h0, bus.S_AXI_ARREADY}, 0);
    exp_mem.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    hang = 1'b0;
    exp_m(1'b0, 12'h010, 32'h0, 4'h0);
    exp_rsp(1'b1, 2'b00, 32'hDEADBEEF);
    do_hs(2, BASE + 32'h10, 32'h0, 4'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
